// File: rtl/multimode_counter_pkg.sv
// Shared constants for the multimode counter: mode encodings and direction values.
package multimode_counter_pkg;

   // Mode select encodings on the M input
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_PP   = 2'b11;

   // Direction flag values reported on dir
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/multimode_counter_bin2gray.sv
// Purely combinational binary to reflected-Gray converter.
module bin2gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   // Each Gray bit is the XOR of the binary bit and its upper neighbour
   always_comb begin
      gray = bin ^ (bin >> 1'b1);
   end

endmodule

// File: rtl/multimode_counter.sv
// WIDTH-bit modulo-MOD counter with hold/up/down/ping-pong modes, synchronous
// load with clamping, optional saturation, terminal-count pulse and Gray copy.
module multimode_counter
   import multimode_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MOD      = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       M,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] gray,
   output logic             tc,
   output logic             dir
);

   // Boundaries in counter width; MOD <= 2**WIDTH keeps these exact
   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

   logic [WIDTH-1:0] count_r;
   logic             dir_r;
   logic             tc_r;

   logic [WIDTH-1:0] count_s;
   logic             dir_s;
   logic             tc_s;
   logic             at_max_s;
   logic             at_min_s;

   // Next-state: load beats enable, enable gates the mode-specific step
   always_comb begin
      count_s  = count_r;
      dir_s    = dir_r;
      tc_s     = 1'b0;
      at_max_s = (count_r == MAX_VAL);
      at_min_s = (count_r == ZERO_VAL);
      if (load) begin
         if (load_val > MAX_VAL) begin
            count_s = MAX_VAL;
         end else begin
            count_s = load_val;
         end
      end else if (en) begin
         case (M)
            MODE_HOLD: begin
               count_s = count_r;
            end
            MODE_UP: begin
               dir_s = DIR_UP;
               if (at_max_s) begin
                  tc_s = 1'b1;
                  if (SATURATE) begin
                     count_s = MAX_VAL;
                  end else begin
                     count_s = ZERO_VAL;
                  end
               end else begin
                  count_s = count_r + ONE_VAL;
               end
            end
            MODE_DOWN: begin
               dir_s = DIR_DOWN;
               if (at_min_s) begin
                  tc_s = 1'b1;
                  if (SATURATE) begin
                     count_s = ZERO_VAL;
                  end else begin
                     count_s = MAX_VAL;
                  end
               end else begin
                  count_s = count_r - ONE_VAL;
               end
            end
            MODE_PP: begin
               // Bounce at either end: step back one and flip direction
               if (dir_r == DIR_UP) begin
                  if (at_max_s) begin
                     count_s = count_r - ONE_VAL;
                     dir_s   = DIR_DOWN;
                     tc_s    = 1'b1;
                  end else begin
                     count_s = count_r + ONE_VAL;
                  end
               end else begin
                  if (at_min_s) begin
                     count_s = ONE_VAL;
                     dir_s   = DIR_UP;
                     tc_s    = 1'b1;
                  end else begin
                     count_s = count_r - ONE_VAL;
                  end
               end
            end
            default: begin
               count_s = count_r;
            end
         endcase
      end else begin
         count_s = count_r;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_r <= ZERO_VAL;
         dir_r   <= DIR_UP;
         tc_r    <= 1'b0;
      end else begin
         count_r <= count_s;
         dir_r   <= dir_s;
         tc_r    <= tc_s;
      end
   end

   assign count = count_r;
   assign dir   = dir_r;
   assign tc    = tc_r;

   bin2gray #(
      .WIDTH (WIDTH)
   ) u_bin2gray (
      .bin  (count_r),
      .gray (gray)
   );

endmodule

// File: tb/tb_multimode_counter.sv
// Self-checking bench: three counters share stimulus and are compared against
// an arithmetic model (modulo 10 wrapping, modulo 10 saturating, modulo 2 wrapping).
module tb_multimode_counter;

   logic       clock;
   logic       rst_n;
   logic       en;
   logic [1:0] m;
   logic       load;
   logic [3:0] load_val;

   logic [3:0] cnt_o  [3];
   logic [3:0] gray_o [3];
   logic       tc_o   [3];
   logic       dir_o  [3];

   int  mods [3] = '{10, 10, 2};
   bit  sats [3] = '{1'b0, 1'b1, 1'b0};
   int  m_cnt [3];
   bit  m_dir [3];
   bit  m_tc  [3];

   int tests = 0;
   int fails = 0;

   multimode_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_wrap (
      .clock(clock), .reset(rst_n), .en(en), .M(m), .load(load), .load_val(load_val),
      .count(cnt_o[0]), .gray(gray_o[0]), .tc(tc_o[0]), .dir(dir_o[0]));

   multimode_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) u_sat (
      .clock(clock), .reset(rst_n), .en(en), .M(m), .load(load), .load_val(load_val),
      .count(cnt_o[1]), .gray(gray_o[1]), .tc(tc_o[1]), .dir(dir_o[1]));

   multimode_counter #(.WIDTH(4), .MOD(2), .SATURATE(1'b0)) u_mod2 (
      .clock(clock), .reset(rst_n), .en(en), .M(m), .load(load), .load_val(load_val),
      .count(cnt_o[2]), .gray(gray_o[2]), .tc(tc_o[2]), .dir(dir_o[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Behavioural next state from the rules: reset, load, enable, then mode
   task automatic model_edge(input int i);
      int c;
      int step;
      c = m_cnt[i];
      if (!rst_n) begin
         m_cnt[i] = 0; m_dir[i] = 1'b1; m_tc[i] = 1'b0;
      end else if (load) begin
         m_cnt[i] = (int'(load_val) < mods[i]) ? int'(load_val) : mods[i] - 1;
         m_tc[i] = 1'b0;
      end else if (!en || m == 2'b00) begin
         m_tc[i] = 1'b0;
      end else if (m == 2'b01) begin
         m_dir[i] = 1'b1;
         m_tc[i]  = (c == mods[i] - 1);
         m_cnt[i] = (sats[i] && m_tc[i]) ? c : (c + 1) % mods[i];
      end else if (m == 2'b10) begin
         m_dir[i] = 1'b0;
         m_tc[i]  = (c == 0);
         m_cnt[i] = (sats[i] && m_tc[i]) ? c : (c + mods[i] - 1) % mods[i];
      end else begin
         step = m_dir[i] ? 1 : -1;
         if (c + step < 0 || c + step > mods[i] - 1) begin
            m_dir[i] = ~m_dir[i];
            m_cnt[i] = c - step;
            m_tc[i]  = 1'b1;
         end else begin
            m_cnt[i] = c + step;
            m_tc[i]  = 1'b0;
         end
      end
   endtask

   // One clock edge: advance the model, then compare every instance
   task automatic step();
      @(posedge clock);
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("count[%0d]", i), cnt_o[i], 4'(m_cnt[i]));
         chk($sformatf("gray[%0d]", i), gray_o[i], 4'(m_cnt[i] ^ (m_cnt[i] >> 1)));
         chk($sformatf("tc[%0d]", i), {3'b000, tc_o[i]}, {3'b000, m_tc[i]});
         chk($sformatf("dir[%0d]", i), {3'b000, dir_o[i]}, {3'b000, m_dir[i]});
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [1:0] mm,
                        input logic l, input logic [3:0] lv);
      rst_n = r; en = e; m = mm; load = l; load_val = lv;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_dir[i] = 1'b1; m_tc[i] = 1'b0;
      end
      drive(1'b0, 1'b1, 2'b01, 1'b1, 4'd5);

      // 1: reset overrides load/en/mode
      step(); step();
      chk("rst_count", cnt_o[0], 4'd0);
      chk("rst_gray", gray_o[0], 4'b0000);
      chk("rst_dir", {3'b000, dir_o[0]}, 4'd1);
      drive(1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
      step();
      chk("first_up", cnt_o[0], 4'd1);

      // 2: count up to 9 then wrap with tc
      for (int k = 0; k < 8; k++) step();
      chk("up_9", cnt_o[0], 4'd9);
      chk("gray_9", gray_o[0], 4'b1101);
      chk("no_tc_9", {3'b000, tc_o[0]}, 4'd0);
      step();
      chk("wrap_0", cnt_o[0], 4'd0);
      chk("wrap_tc", {3'b000, tc_o[0]}, 4'd1);

      // 3: down from 0 wraps to 9; saturating copy holds at 0
      drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
      step();
      chk("down_wrap", cnt_o[0], 4'd9);
      chk("down_tc", {3'b000, tc_o[0]}, 4'd1);
      chk("down_dir", {3'b000, dir_o[0]}, 4'd0);
      step();
      chk("down_8", cnt_o[0], 4'd8);
      drive(1'b1, 1'b1, 2'b10, 1'b1, 4'd0);
      step();
      drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
      step(); step();
      chk("sat_low", cnt_o[1], 4'd0);
      chk("sat_low_tc", {3'b000, tc_o[1]}, 4'd1);

      // 4: ping-pong from 7 going up bounces at 9
      drive(1'b1, 1'b1, 2'b01, 1'b1, 4'd6);
      step();
      drive(1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
      step();
      drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
      step(); step(); step();
      chk("pp_bounce", cnt_o[0], 4'd8);
      chk("pp_tc", {3'b000, tc_o[0]}, 4'd1);
      chk("pp_dir", {3'b000, dir_o[0]}, 4'd0);
      step();
      chk("pp_7", cnt_o[0], 4'd7);
      for (int k = 0; k < 8; k++) step();
      chk("pp_low", cnt_o[0], 4'd1);
      chk("pp_low_dir", {3'b000, dir_o[0]}, 4'd1);

      // 5: clamped load, disabled hold, saturate at top
      drive(1'b1, 1'b0, 2'b01, 1'b1, 4'd12);
      step();
      chk("clamp", cnt_o[0], 4'd9);
      drive(1'b1, 1'b0, 2'b01, 1'b0, 4'd0);
      step(); step(); step();
      chk("en_hold", cnt_o[0], 4'd9);
      drive(1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
      step(); step();
      chk("sat_high", cnt_o[1], 4'd9);
      chk("sat_high_tc", {3'b000, tc_o[1]}, 4'd1);

      // 6: reset in mid ping-pong restarts upward
      drive(1'b1, 1'b1, 2'b10, 1'b1, 4'd6);
      step();
      drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
      step();
      drive(1'b0, 1'b1, 2'b11, 1'b0, 4'd0);
      step();
      chk("mid_rst", cnt_o[0], 4'd0);
      drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
      step(); step();
      chk("after_rst", cnt_o[0], 4'd2);

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
               2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
               4'($urandom_range(0, 15)));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
